// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: bus widths, one-hot load-op bit positions and MEM state encoding
package mem_stage_pkg;
   localparam int RF_W  = 38;
   localparam int CSR_W = 79;
   localparam int EXC_W = 7;
   localparam int FWD_W = 39;
   localparam int LD_B  = 0;
   localparam int LD_BU = 1;
   localparam int LD_H  = 2;
   localparam int LD_HU = 3;
   localparam int LD_W  = 4;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_HOLD = 2'd2} mem_state_t;
endpackage

// File: rtl/mem_stage_load_ext.sv
// load_ext: selects and extends the loaded byte/halfword/word; non-loads yield 0
module load_ext
   import mem_stage_pkg::*;
(
   input  logic [4:0]  ld_op,
   input  logic [1:0]  addr,
   input  logic [31:0] rdata,
   output logic [31:0] wdata
);
   logic [7:0]  b;
   logic [15:0] h;
   assign b = rdata[{addr, 3'b000} +: 8];
   assign h = addr[1] ? rdata[31:16] : rdata[15:0];
   assign wdata = ld_op[LD_B]  ? {{24{b[7]}}, b}  :
                  ld_op[LD_BU] ? {24'd0, b}        :
                  ld_op[LD_H]  ? {{16{h[15]}}, h} :
                  ld_op[LD_HU] ? {16'd0, h}        :
                  ld_op[LD_W]  ? rdata             : 32'd0;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: LoongArch MEM stage; waits for data responses and drops those of flushed requests.
// MEM_LOAD_FWD_EN: forward extended load data in its data_ok cycle instead of stalling decode.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   output logic             mem_allowin,
   input  logic             ex_to_mem_valid,
   input  logic [31:0]      ex_pc,
   input  logic [RF_W-1:0]  ex_rf_all,
   input  logic [4:0]       ex_ld_op,
   input  logic             ex_mem_req,
   input  logic [CSR_W-1:0] ex_csr_rf,
   input  logic [EXC_W-1:0] ex_exc_rf,
   input  logic [31:0]      ex_fault_vaddr,
   input  logic             data_sram_req,
   input  logic             data_sram_addr_ok,
   input  logic             data_sram_data_ok,
   input  logic [31:0]      data_sram_rdata,
   input  logic             wb_allowin,
   input  logic             cancel_exc_ertn,
   output logic             mem_to_wb_valid,
   output logic [31:0]      mem_pc,
   output logic [RF_W-1:0]  mem_rf_all,
   output logic [CSR_W-1:0] mem_csr_rf,
   output logic [EXC_W-1:0] mem_exc_rf,
   output logic [31:0]      mem_fault_vaddr,
   output logic [FWD_W-1:0] mem_fwd,
   output logic             mem_exc_block
);
   mem_state_t      st, st_nxt;
   logic            mem_valid;
   logic [RF_W-1:0] mem_rf;
   logic [4:0]      mem_ld_op;
   logic            mem_ex_mem_req;
   logic [1:0]      out_cnt, dis_cnt, out_nxt;
   logic [31:0]     rdata_buf, ld_src, ext_data, rf_wdata;
   logic            need_data, req_hs, dok_acc, ready_go, capture, data_pending, fwd_we;

   assign req_hs    = data_sram_req & data_sram_addr_ok;
   assign out_nxt   = out_cnt + {1'b0, req_hs} - {1'b0, data_sram_data_ok};
   // a response is ours only once every flushed request has drained
   assign dok_acc   = data_sram_data_ok & (dis_cnt == 2'd0);
   assign need_data = mem_ex_mem_req & ~|mem_exc_rf;
   assign ready_go  = ~need_data | (st == ST_HOLD) | ((st == ST_WAIT) & dok_acc);
   assign mem_allowin     = ~mem_valid | (ready_go & wb_allowin);
   assign mem_to_wb_valid = mem_valid & ready_go & ~cancel_exc_ertn;
   assign capture   = ex_to_mem_valid & mem_allowin;

   always_comb begin
      st_nxt = cancel_exc_ertn ? ST_IDLE :
               mem_allowin ? ((capture & ex_mem_req & ~|ex_exc_rf) ? ST_WAIT : ST_IDLE) :
               ((st == ST_WAIT) & dok_acc) ? ST_HOLD : st;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st              <= ST_IDLE;
         mem_valid       <= 1'b0;
         out_cnt         <= 2'd0;
         dis_cnt         <= 2'd0;
         rdata_buf       <= 32'd0;
         mem_pc          <= 32'd0;
         mem_rf          <= '0;
         mem_ld_op       <= 5'd0;
         mem_ex_mem_req  <= 1'b0;
         mem_csr_rf      <= '0;
         mem_exc_rf      <= '0;
         mem_fault_vaddr <= 32'd0;
      end else begin
         st        <= st_nxt;
         out_cnt   <= out_nxt;
         dis_cnt   <= cancel_exc_ertn ? out_nxt :
                      (data_sram_data_ok & (dis_cnt != 2'd0)) ? dis_cnt - 2'd1 : dis_cnt;
         mem_valid <= cancel_exc_ertn ? 1'b0 : mem_allowin ? ex_to_mem_valid : mem_valid;
         if (capture) begin
            mem_pc          <= ex_pc;
            mem_rf          <= ex_rf_all;
            mem_ld_op       <= ex_ld_op;
            mem_ex_mem_req  <= ex_mem_req;
            mem_csr_rf      <= ex_csr_rf;
            mem_exc_rf      <= ex_exc_rf;
            mem_fault_vaddr <= ex_fault_vaddr;
         end
         if ((st == ST_WAIT) & dok_acc)
            rdata_buf <= data_sram_rdata;
      end
   end

   assign ld_src = (st == ST_HOLD) ? rdata_buf : data_sram_rdata;

   load_ext u_load_ext (
      .ld_op (mem_ld_op),
      .addr  (mem_rf[1:0]),
      .rdata (ld_src),
      .wdata (ext_data)
   );

   assign rf_wdata = |mem_ld_op ? ext_data : mem_rf[31:0];
   assign fwd_we   = mem_valid & mem_rf[37] & ~|mem_exc_rf;
`ifdef MEM_LOAD_FWD_EN
   assign data_pending = mem_valid & (st == ST_WAIT) & ~dok_acc;
`else
   assign data_pending = mem_valid & |mem_ld_op;
`endif
   assign mem_rf_all    = {mem_rf[37:32], rf_wdata};
   assign mem_fwd       = {data_pending, fwd_we, mem_rf[36:32], rf_wdata};
   assign mem_exc_block = mem_valid & |mem_exc_rf;
endmodule
